// File: rtl/adder_pkg.sv
// adder_pkg: FSM state type and minimum-1 counter-width helper clog2 shared by multicycle_adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: W-bit full-adder ripple; ports a, b, cin -> sum, cout, cmsb (carry into the top bit)
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  logic [W:0] c;
  always_comb begin
    c[0] = cin;
    for (int k = 0; k < W; k++) begin
      sum[k] = a[k] ^ b[k] ^ c[k];
      c[k+1] = a[k] & b[k] | c[k] & (a[k] ^ b[k]);
    end
  end
  assign cout = c[W];
  assign cmsb = c[W-1];
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: CHUNK-bits-per-clock adder; clk, reset_n, in_valid/in_ready + a, b, carryin (sub with ADDER_SUB_EN) -> out_valid/out_ready + sum, carryout, overflow
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW = clog2(NCH);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, acc, acc_n, bin;
  logic [CHUNK-1:0] cs;
  logic c, cin0, cout, cmsb, last;
`ifdef ADDER_SUB_EN
  assign bin = sub ? ~b : b;
  assign cin0 = sub | carryin;
`else
  assign bin = b;
  assign cin0 = carryin;
`endif
  assign last = cnt == LAST;
  // operands shift down so the current chunk is always the low CHUNK bits; results enter from the top
  assign acc_n = (acc >> CHUNK) | (WIDTH'(cs) << (WIDTH - CHUNK));
  chunk_adder #(.W(CHUNK)) u_chunk (
    .a(ra[CHUNK-1:0]),
    .b(rb[CHUNK-1:0]),
    .cin(c),
    .sum(cs),
    .cout(cout),
    .cmsb(cmsb)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              out_ready     ? IDLE : DONE;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // sum/carryout/overflow only change on the final chunk so they hold through DONE and after it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      c <= 1'b0;
      sum <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      cnt <= '0;
      ra <= a;
      rb <= bin;
      c <= cin0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      ra <= ra >> CHUNK;
      rb <= rb >> CHUNK;
      acc <= acc_n;
      c <= cout;
      if (last) begin
        sum <= acc_n;
        carryout <= cout;
        overflow <= cout ^ cmsb;
      end
    end
endmodule
